// File: rtl/sobel_result_streamer_pkg.sv
// Shared types for the Sobel result streamer.
// FSM encodings and output buffer depth.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sobel_result_streamer_if.sv
// Pixel stream bundle: valid/ready with line and frame markers.
// The streamer drives it as master.
interface sobel_result_streamer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_eol;
   logic                  m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_eol,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_eol,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/sobel_result_streamer_fifo.sv
// Two-entry synchronous FIFO for {last, eol, data} beats.
// Push on full is accepted only together with a pop.
import sobel_pkg::*;

module stream_fifo2 #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [FIFO_DEPTH];
   logic         r_wr;
   logic         r_rd;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign o_full  = (r_cnt == 2'(FIFO_DEPTH));
   assign o_empty = (r_cnt == 2'd0);
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rd];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cnt <= 2'd0;
      end else if (i_flush) begin
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end
         if (w_pop)
            r_rd <= ~r_rd;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/sobel_result_streamer.sv
// Reads the Sobel result BRAM and streams it out as a
// valid/ready pixel stream with eol/last markers.
import sobel_pkg::*;

module sobel_result_streamer #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 12,
   parameter int IMAGE_WIDTH  = 100,
   parameter int IMAGE_HEIGHT = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_num_cnt,
   output logic                  o_idle,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  b_ce0,
   output logic                  b_we0,
   output logic [ADDR_WIDTH-1:0] b_addr0,
   output logic [DATA_WIDTH-1:0] b_d0,
   input  logic [DATA_WIDTH-1:0] b_q0,
   sobel_result_streamer_if.master m
);

   localparam int CW = $clog2(IMAGE_WIDTH + 1);
   localparam int FW = DATA_WIDTH + 2;

   if (IMAGE_WIDTH < 2 || IMAGE_HEIGHT < 1) begin : g_bad_geom
      $error("sobel_result_streamer: bad image geometry");
   end

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CW-1:0]         r_col;
   logic                  r_inflight;
   logic                  r_inf_eol;
   logic                  r_inf_last;

   logic                  w_start;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_credit;
   logic [2:0]            w_occ;
   logic                  w_is_last;
   logic                  w_is_eol;
   logic [FW-1:0]         w_head;
   logic                  w_full;
   logic                  w_empty;
   logic [1:0]            w_fcnt;

   assign w_start = (r_state == ST_IDLE) & i_start;
   assign w_pop   = m.m_valid & m.m_ready;

   // Occupancy after this cycle's pop, counting the read still in the BRAM.
   assign w_occ    = 3'(w_fcnt) + 3'(r_inflight) - 3'(w_pop);
   assign w_credit = (w_occ < 3'(FIFO_DEPTH));
   assign w_issue  = (r_state == ST_RUN) & (r_addr < r_cnt) & w_credit;

   assign w_is_last = (r_addr == r_cnt - ADDR_WIDTH'(1));
   assign w_is_eol  = (r_col == CW'(IMAGE_WIDTH - 1)) | w_is_last;

   assign b_ce0   = w_issue;
   assign b_we0   = 1'b0;
   assign b_addr0 = r_addr;
   assign b_d0    = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start)
               w_next = (i_num_cnt == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (w_pop & w_head[FW-1])
               w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_idle = 1'b0;
      o_busy = 1'b0;
      o_done = 1'b0;
      unique case (r_state)
         ST_IDLE: o_idle = 1'b1;
         ST_RUN:  o_busy = 1'b1;
         ST_DONE: o_done = 1'b1;
         default: o_idle = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_addr     <= '0;
         r_col      <= '0;
         r_inflight <= 1'b0;
         r_inf_eol  <= 1'b0;
         r_inf_last <= 1'b0;
      end else if (w_start) begin
         r_cnt      <= i_num_cnt;
         r_addr     <= '0;
         r_col      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_inf_eol  <= w_is_eol;
            r_inf_last <= w_is_last;
            if (r_col == CW'(IMAGE_WIDTH - 1))
               r_col <= '0;
            else
               r_col <= r_col + CW'(1);
         end
      end
   end

   stream_fifo2 #(.W(FW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_start),
      .i_push  (r_inflight),
      .i_data  ({r_inf_last, r_inf_eol, b_q0}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fcnt)
   );

   assign m.m_valid = ~w_empty;
   assign m.m_data  = w_head[DATA_WIDTH-1:0];
   assign m.m_eol   = w_head[DATA_WIDTH];
   assign m.m_last  = w_head[FW-1];

   logic w_unused;
   assign w_unused = w_full;

endmodule

// File: tb/tb_sobel_result_streamer.sv
// Directed bench: BRAM model holds mem[a]=a[7:0], frames are
// streamed and every beat, flag and done pulse is checked.
module tb_sobel_result_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start;
   logic [11:0] i_num_cnt;
   logic        o_idle;
   logic        o_busy;
   logic        o_done;
   logic        b_ce0;
   logic        b_we0;
   logic [11:0] b_addr0;
   logic [7:0]  b_d0;
   logic [7:0]  b_q0;
   logic [7:0]  mem [4096];

   int n_tests = 0;
   int n_fail  = 0;

   sobel_result_streamer_if #(.DATA_WIDTH(8)) s_if ();

   sobel_result_streamer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (i_start),
      .i_num_cnt (i_num_cnt),
      .o_idle    (o_idle),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .b_ce0     (b_ce0),
      .b_we0     (b_we0),
      .b_addr0   (b_addr0),
      .b_d0      (b_d0),
      .b_q0      (b_q0),
      .m         (s_if.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (b_ce0)
         b_q0 <= mem[b_addr0];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic run_frame(input int cnt,
                            input int rnd,
                            input int restart_at);
      int        cyc;
      int        idx;
      int        dones;
      int        done_cyc;
      int        budget;
      bit        fin;
      bit        stall;
      logic [7:0] sd;
      logic      se;
      logic      sl;
      cyc = 0; idx = 0; dones = 0; done_cyc = 0;
      fin = 0; stall = 0; sd = 0; se = 0; sl = 0;
      budget = cnt * 8 + 40;
      @(posedge clk); #1;
      i_start   = 1'b1;
      i_num_cnt = 12'(cnt);
      s_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!fin && cyc < budget) begin
         @(negedge clk);
         if (stall) begin
            chk("stall_valid", 32'(s_if.m_valid), 1);
            chk("stall_data", 32'(s_if.m_data), 32'(sd));
            chk("stall_eol", 32'(s_if.m_eol), 32'(se));
            chk("stall_last", 32'(s_if.m_last), 32'(sl));
         end
         if (cnt == 0) begin
            chk("zero_ce", 32'(b_ce0), 0);
            chk("zero_valid", 32'(s_if.m_valid), 0);
         end
         if (s_if.m_valid && s_if.m_ready) begin
            if (idx < cnt) begin
               chk("data", 32'(s_if.m_data), idx % 256);
               chk("eol", 32'(s_if.m_eol),
                   32'((idx % 100 == 99) || (idx == cnt - 1)));
               chk("last", 32'(s_if.m_last),
                   32'(idx == cnt - 1));
            end else begin
               chk("extra_beat", idx, cnt - 1);
            end
            idx++;
         end
         stall = s_if.m_valid && !s_if.m_ready;
         sd = s_if.m_data;
         se = s_if.m_eol;
         sl = s_if.m_last;
         if (o_done) begin
            dones++;
            done_cyc = cyc;
         end
         if (dones > 0 && cyc >= done_cyc + 2)
            fin = 1;
         @(posedge clk); #1;
         i_start = (restart_at > 0 && cyc + 1 == restart_at);
         if (i_start)
            i_num_cnt = 12'd3;
         if (rnd)
            s_if.m_ready = 1'($urandom_range(0, 1));
         cyc++;
      end
      i_start = 1'b0;
      if (!fin)
         chk("timeout", 0, 1);
      chk("beats", idx, cnt);
      chk("done_count", dones, 1);
      if (!rnd)
         chk("done_cycle", done_cyc, cnt == 0 ? 1 : cnt + 3);
      chk("idle_after", 32'(o_idle), 1);
   endtask

   initial begin
      int beats;
      int dones;
      int guard;
      for (int a = 0; a < 4096; a++)
         mem[a] = 8'(a);
      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_num_cnt    = '0;
      s_if.m_ready = 1'b0;
      #3;
      chk("rst_idle", 32'(o_idle), 1);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_ce", 32'(b_ce0), 0);
      chk("rst_valid", 32'(s_if.m_valid), 0);
      chk("rst_addr", 32'(b_addr0), 0);
      chk("rst_we", 32'(b_we0), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ce", 32'(b_ce0), 0);
      end

      run_frame(250, 0, 0);
      run_frame(250, 1, 0);
      run_frame(0, 0, 0);
      run_frame(10, 0, 5);

      // abort a frame mid-stream under backpressure
      @(posedge clk); #1;
      i_start      = 1'b1;
      i_num_cnt    = 12'd250;
      s_if.m_ready = 1'b1;
      beats = 0; dones = 0; guard = 0;
      while (beats < 40 && guard < 200) begin
         @(negedge clk);
         if (s_if.m_valid && s_if.m_ready)
            beats++;
         if (o_done)
            dones++;
         @(posedge clk); #1;
         i_start = 1'b0;
         if (beats >= 40)
            s_if.m_ready = 1'b0;
         guard++;
      end
      chk("abort_beats", beats, 40);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_idle", 32'(o_idle), 1);
      chk("abort_busy", 32'(o_busy), 0);
      chk("abort_done", 32'(o_done), 0);
      chk("abort_ce", 32'(b_ce0), 0);
      chk("abort_addr", 32'(b_addr0), 0);
      chk("abort_valid", 32'(s_if.m_valid), 0);
      chk("abort_data", 32'(s_if.m_data), 0);
      chk("abort_eol", 32'(s_if.m_eol), 0);
      chk("abort_last", 32'(s_if.m_last), 0);
      chk("abort_no_done", dones, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_frame(4, 0, 0);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
